usb_tx_sequencer: RTL

//  Transmit-side packet sequencer for the USB 2.0 serial interface engine. Takes a PID, byte count and

---
 rtl/usb_sie_pkg.sv | 14 +
 rtl/usb_crc16_serial.sv | 16 +
 rtl/usb_tx_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/usb_sie_pkg.sv
// usb_sie_pkg: shared types and constants for the USB serial interface engine
package usb_sie_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP, S_GAP} state_t;
  localparam logic [3:0] PID_ACK = 4'h2;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [7:0] SYNC_PAT = 8'h80;
  localparam int CRC_W = 16;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h8005;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] c, input logic d);
    return {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ d) ? CRC_POLY : '0);
  endfunction
endpackage

// File: rtl/usb_crc16_serial.sv
// usb_crc16_serial: bit-serial USB CRC16 register, one payload bit per enabled cycle
module usb_crc16_serial
  import usb_sie_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en) crc <= crc16_step(crc, din);
endmodule

// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer: serialises SYNC, PID, payload, CRC16 and EOP for the USB transmit path
module usb_tx_sequencer
  import usb_sie_pkg::*;
#(
  parameter int MAX_BYTES = 64,
  parameter int EOP_BITS  = 2,
  parameter int IDLE_GAP  = 3,
  localparam int CW = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_start,
  input  logic [3:0]    tx_pid,
  input  logic [CW-1:0] tx_len,
  input  logic [7:0]    tx_data,
  input  logic          tx_data_valid,
  output logic          tx_data_ready,
  input  logic          stuff_stall,
  output logic          ser_bit,
  output logic          ser_valid,
  output logic          se0,
  output logic          en_bitstuff,
  output logic          en_nrziencoder,
  output logic          busy,
  output logic          done,
  output logic          tx_err
);
  state_t st, nx;
  logic [3:0] cnt, lim, pid;
  logic [CW-1:0] rem;
  logic [7:0] sh, pid_byte;
  logic [CRC_W-1:0] crc, crc_nx, crc_src;
  logic [2:0] idx;
  logic hold, last, slot, has_crc, crc_bit, bit_nx;

  assign hold = stuff_stall && st != S_IDLE && st != S_GAP;
  assign lim = st == S_CRC ? 4'd15 : st == S_EOP ? 4'(EOP_BITS - 1) :
               st == S_GAP ? 4'(IDLE_GAP - 1) : 4'd7;
  assign last = cnt == lim;
  assign slot = (st == S_PID || st == S_DATA) && last && rem != '0;
  assign tx_data_ready = slot & tx_data_valid & ~stuff_stall;
  assign has_crc = pid[1:0] == PID_DATA0[1:0];
  assign pid_byte = {~pid, pid};

  // Leaving PID or a byte: load the next byte, fall into CRC, or abort to EOP on underrun
  assign nx = hold ? st :
              st == S_IDLE ? (tx_start ? S_SYNC : S_IDLE) :
              !last ? st :
              st == S_SYNC ? S_PID :
              (st == S_PID || st == S_DATA) ?
                (rem != '0 ? (tx_data_valid ? S_DATA : S_EOP) : has_crc ? S_CRC : S_EOP) :
              st == S_CRC ? S_EOP :
              st == S_EOP ? S_GAP : S_IDLE;

  usb_crc16_serial u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (st == S_SYNC),
    .en   (st == S_DATA && !stuff_stall),
    .din  (ser_bit),
    .crc  (crc)
  );

  // The final payload bit is folded in on the same edge the first CRC bit is registered
  assign crc_nx = crc16_step(crc, ser_bit);
  assign crc_src = st == S_DATA ? crc_nx : crc;
  assign crc_bit = st == S_CRC ? ~crc[4'd14 - cnt] : ~crc_src[CRC_W-1];
  assign idx = (nx == st && !last) ? cnt[2:0] + 3'd1 : 3'd0;
  assign bit_nx = nx == S_SYNC ? SYNC_PAT[idx] :
                  nx == S_PID  ? pid_byte[idx] :
                  nx == S_DATA ? (idx == 3'd0 ? tx_data[0] : sh[idx]) :
                  nx == S_CRC  ? crc_bit : 1'b0;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st             <= S_IDLE;
      cnt            <= '0;
      pid            <= '0;
      rem            <= '0;
      sh             <= '0;
      ser_bit        <= 1'b0;
      ser_valid      <= 1'b0;
      se0            <= 1'b0;
      en_bitstuff    <= 1'b0;
      en_nrziencoder <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      tx_err         <= 1'b0;
    end else begin
      done   <= st == S_GAP && last;
      tx_err <= slot & ~tx_data_valid & ~stuff_stall;
      if (!hold) begin
        st             <= nx;
        cnt            <= (nx != st || last || st == S_IDLE) ? 4'd0 : cnt + 4'd1;
        ser_bit        <= bit_nx;
        ser_valid      <= nx inside {S_SYNC, S_PID, S_DATA, S_CRC};
        en_nrziencoder <= nx inside {S_SYNC, S_PID, S_DATA, S_CRC};
        en_bitstuff    <= nx inside {S_PID, S_DATA, S_CRC};
        se0            <= nx == S_EOP;
        busy           <= nx != S_IDLE;
        if (st == S_IDLE) begin
          pid <= tx_pid;
          rem <= tx_len > CW'(MAX_BYTES) ? CW'(MAX_BYTES) : tx_len;
        end
        if (tx_data_ready) begin
          sh  <= tx_data;
          rem <= rem - 1'b1;
        end
      end
    end
endmodule
